// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the fetch sequencer slice.
// State encodings, default bubble opcode and program-counter width.
package fetch_pkg;

  localparam int unsigned PC_W = 16;

  localparam logic [7:0] NOP_OPCODE_DEFAULT = 8'h00;

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] FLUSH  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

endpackage

// File: rtl/fetch_sequencer_pc_register.sv
// pc_register: program counter with synchronous active-low reset to a
// vector, parallel load (branch) and increment enable (fetch).
// Load wins over increment.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_load_val,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  // PC update: reset, branch load, or 16-bit wrapping increment
  always_ff @(posedge clk) begin
    if (!rst_b)      r_pc <= RESET_VECTOR;
    else if (i_load) r_pc <= i_load_val;
    else if (i_inc)  r_pc <= r_pc + 1'b1;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front-end controller. Owns the PC, fetches one opcode
// per cycle from the shared bus, yields the bus to the data stage, and
// inserts NOP bubbles on steal, branch flush and halt.
//
// Optional feature: FETCH_SEQ_STALL_COUNT_EN builds a saturating bubble
// counter on STALL_COUNT; without it STALL_COUNT is tied to zero.
//
//   state  | meaning
//   FETCH  | normal fetch, one opcode per cycle unless stolen/halted
//   FLUSH  | post-branch bubbles, counts the flush counter down
//   HALTED | fetching stopped while HALT is high, bus still served
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [7:0]      NOP_OPCODE   = NOP_OPCODE_DEFAULT,
  parameter logic [PC_W-1:0] RESET_VECTOR = 16'h0000,
  parameter int unsigned     FLUSH_DEPTH  = 2
) (
  input  logic            CLK,
  input  logic            RST_bar,
  output logic [PC_W-1:0] MEM_ADDR,
  output logic            MEM_RD_bar,
  input  logic [7:0]      MEM_DATA,
  input  logic            DATA_REQ,
  input  logic [PC_W-1:0] DATA_ADDR,
  output logic            DATA_GNT,
  input  logic            BRANCH_TAKE,
  input  logic [PC_W-1:0] BRANCH_TARGET,
  input  logic            HALT,
  output logic [7:0]      OPCODE_OUT,
  output logic [PC_W-1:0] PC_OUT,
  output logic [15:0]     STALL_COUNT
);

  localparam logic [1:0] FLUSH_INIT = FLUSH_DEPTH[1:0];

  logic [1:0]      r_state;
  logic [1:0]      r_flush_cnt;
  logic [7:0]      r_opcode;
  logic [1:0]      w_state_nxt;
  logic [1:0]      w_cnt_nxt;
  logic [PC_W-1:0] w_pc;
  logic            w_grant;
  logic            w_fetch;

  // A real fetch happens only in FETCH with the bus free and no branch/halt;
  // every other non-reset edge loads a bubble.
  assign w_grant    = RST_bar & DATA_REQ;
  assign w_fetch    = RST_bar & (r_state == FETCH) & ~HALT & ~DATA_REQ & ~BRANCH_TAKE;
  assign DATA_GNT   = w_grant;
  assign MEM_ADDR   = w_grant ? DATA_ADDR : w_pc;
  assign MEM_RD_bar = ~(w_grant | w_fetch);

  pc_register #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc (
    .clk        (CLK),
    .rst_b      (RST_bar),
    .i_load     (BRANCH_TAKE),
    .i_load_val (BRANCH_TARGET),
    .i_inc      (w_fetch),
    .o_pc       (w_pc)
  );

  // Next-state and flush-counter logic; a taken branch overrides any state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_flush_cnt;
    if (BRANCH_TAKE) begin
      w_cnt_nxt = FLUSH_INIT;
      if (HALT)                    w_state_nxt = HALTED;
      else if (FLUSH_INIT != 2'd0) w_state_nxt = FLUSH;
      else                         w_state_nxt = FETCH;
    end else begin
      case (r_state)
        FETCH:  if (HALT) w_state_nxt = HALTED;
        FLUSH: begin
          w_cnt_nxt = r_flush_cnt - 2'd1;
          // leave on the last flush cycle; a zero count is treated the same
          if (r_flush_cnt <= 2'd1) w_state_nxt = HALT ? HALTED : FETCH;
        end
        HALTED: if (!HALT) w_state_nxt = FETCH;
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  // State, flush counter and opcode output registers
  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      r_state     <= FETCH;
      r_flush_cnt <= 2'd0;
      r_opcode    <= NOP_OPCODE;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_cnt_nxt;
      r_opcode    <= w_fetch ? MEM_DATA : NOP_OPCODE;
    end
  end

  assign OPCODE_OUT = r_opcode;
  assign PC_OUT     = w_pc;

`ifdef FETCH_SEQ_STALL_COUNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of bubbles loaded into OPCODE_OUT
  always_ff @(posedge CLK) begin
    if (!RST_bar)                                   r_stall_cnt <= 16'h0000;
    else if (!w_fetch && r_stall_cnt != 16'hFFFF)   r_stall_cnt <= r_stall_cnt + 16'h0001;
  end

  assign STALL_COUNT = r_stall_cnt;
`else
  assign STALL_COUNT = 16'h0000;
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Front-end controller for the opcode pipeline: owns the program counter, fetches one opcode per cycle from the shared memory bus, and drives the first pipeline stage's opcode input. It arbitrates the single memory bus between instruction fetch and the data stage, with the data stage always winning. It inserts NOP bubbles whenever no valid opcode can be fetched: data-stage bus steal, taken-branch flush, or halt.

## Interface
- `NOP_OPCODE`, 8'h00: opcode emitted as a bubble; decodes to all-inactive control lines.
- `RESET_VECTOR`, 16'h0000: PC value after reset.
- `FLUSH_DEPTH`, 2: extra NOP cycles after a taken branch, legal range 0..3.
- `CLK`  in  1: rising-edge clock.
- `RST_bar`  in  1: synchronous, active-low reset.
- `MEM_ADDR`  out  16: memory address; PC when fetching, `DATA_ADDR` when granted.
- `MEM_RD_bar`  out  1: low when the bus performs a read this cycle.
- `MEM_DATA`  in  8: memory read data, valid before the next rising edge.
- `DATA_REQ`  in  1: data stage requests the bus this cycle.
- `DATA_ADDR`  in  16: data-stage address.
- `DATA_GNT`  out  1: combinational grant; equals `DATA_REQ` unless in reset.
- `BRANCH_TAKE`  in  1: load PC from `BRANCH_TARGET` at this edge.
- `BRANCH_TARGET`  in  16: branch destination.
- `HALT`  in  1: stop fetching while high.
- `OPCODE_OUT`  out  8: registered opcode, connects to the stage-0 opcode input.
- `PC_OUT`  out  16: current PC, registered.
- `STALL_COUNT`  out  16: number of bubbles inserted (see Configuration).

## Operation
- FSM states: FETCH, FLUSH, HALTED. Reset is not a state.
- **Reset** (`RST_bar` low at an edge):
  - PC becomes `RESET_VECTOR`; `OPCODE_OUT` becomes `NOP_OPCODE`; state becomes FETCH; flush counter clears; `STALL_COUNT` becomes 0.
  - While `RST_bar` is low: `MEM_RD_bar`=1, `DATA_GNT`=0, `MEM_ADDR`=PC.
- **FETCH, no other event:**
  - `MEM_ADDR`=PC, `MEM_RD_bar`=0.
  - At the edge: `OPCODE_OUT`<=`MEM_DATA`, PC<=PC+1 (16-bit, FFFF wraps to 0000).
- **Data steal** (`DATA_REQ`=1, any state):
  - `MEM_ADDR`=`DATA_ADDR`, `MEM_RD_bar`=0, `DATA_GNT`=1.
  - No fetch this cycle: `OPCODE_OUT`<=NOP and PC holds. An exception applies when a branch is taken in the same cycle (next rule).
- **Branch** (`BRANCH_TAKE`=1, any state):
  - PC<=`BRANCH_TARGET`, `OPCODE_OUT`<=NOP, flush counter<=`FLUSH_DEPTH`.
  - Next state is FLUSH if `FLUSH_DEPTH`>0, else FETCH. If `HALT` is high, next state is HALTED instead.
  - Branch has priority over PC increment. It coexists with a data steal: the bus goes to data and the PC still loads.
- **FLUSH:**
  - No fetch: `MEM_RD_bar`=1 unless the data stage is granted. `OPCODE_OUT`<=NOP.
  - Counter decrements; leave for FETCH in the cycle the counter reaches 1.
  - `HALT` in FLUSH goes to HALTED once the counter expires.
- **HALTED:**
  - Entered from FETCH when `HALT`=1. The cycle that samples `HALT` performs no fetch and emits NOP.
  - Stays while `HALT`=1: PC holds, NOPs are emitted, data requests are still served.
  - `HALT`=0 returns to FETCH at the next edge.
- **Priority:** reset > branch (PC) > data steal (bus) > halt > fetch.

## Timing
- Fetch latency is 1 cycle: the address is presented in cycle n and the opcode appears on `OPCODE_OUT` after edge n.
- `DATA_GNT` and `MEM_ADDR` are combinational from `DATA_REQ`/`DATA_ADDR` and state. No registered handshake; the requester holds `DATA_REQ` for exactly the cycles it needs.
- Taken branch: the first target opcode appears on `OPCODE_OUT` 2+`FLUSH_DEPTH` edges after the branch edge. `PC_OUT` shows the target 1 edge after.
- All outputs except `DATA_GNT`, `MEM_ADDR` and `MEM_RD_bar` are registered.

## Configuration
- `FETCH_SEQ_STALL_COUNT_EN` defined: `STALL_COUNT` increments at every non-reset edge where `OPCODE_OUT` is loaded with NOP due to steal, flush, branch or halt. It saturates at FFFF and is cleared by reset.
- Not defined: `STALL_COUNT` is constant 0 and no counter register is built.

## Structure
- Shared package `fetch_pkg`:
  - state encoding constants FETCH=2'd0, FLUSH=2'd1, HALTED=2'd2;
  - `NOP_OPCODE` default;
  - PC width constant 16.
- One sub-module, `pc_register`: 16-bit register with synchronous active-low reset to vector, load, and increment enable. The FSM, arbiter mux and counter stay in the top level.

## Test plan
- Reset with `RESET_VECTOR`=16'h0100, memory 0100..0102 = A9,05,EA, then release: `OPCODE_OUT` shows A9,05,EA on three consecutive edges; `PC_OUT` shows 0101,0102,0103.
- `DATA_REQ` for 2 cycles at `DATA_ADDR`=8000 mid-stream:
  - `MEM_ADDR`=8000 and `DATA_GNT`=1 for both cycles;
  - two NOPs emitted; PC frozen, then fetch resumes at the same PC with no opcode lost.
- `BRANCH_TAKE` to 0200 with `FLUSH_DEPTH`=2: NOP,NOP,NOP on `OPCODE_OUT`, then mem[0200]; `MEM_RD_bar`=1 during the two flush cycles.
- Branch and `DATA_REQ` in the same cycle: data granted; PC=0200 next cycle; flush proceeds normally.
- `HALT` high for 5 cycles with one `DATA_REQ` inside: NOPs throughout, PC constant, data access granted; fetch resumes at the held PC one edge after `HALT` falls. PC at FFFF wraps to 0000.
- `RST_bar` low during FLUSH: next edge gives PC=`RESET_VECTOR`, state FETCH, `OPCODE_OUT`=NOP, and `STALL_COUNT`=0 (macro defined).
